// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: opcode classes, load
// funct3 codes and the load-data formatting helpers.
package wb_pkg;

    localparam int WB_XLEN = 32;

    // Opcode class taken from the internal opcode's upper bits
    typedef enum logic [1:0] {
        OPC_ALU  = 2'd0,
        OPC_LOAD = 2'd1,
        OPC_STBR = 2'd2,
        OPC_JMP  = 2'd3
    } opc_class_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Bit 5 clear means ALU; otherwise bits [4:3] select the class.
    function automatic opc_class_e opc_class(input logic [5:0] opcode);
        opc_class_e cls;
        if (!opcode[5]) begin
            cls = OPC_ALU;
        end else begin
            case (opcode[4:3])
                2'b00:   cls = OPC_LOAD;
                2'b11:   cls = OPC_JMP;
                default: cls = OPC_STBR;
            endcase
        end
        return cls;
    endfunction

    function automatic logic load_f3_known(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        case (f3)
            F3_LH, F3_LHU: mis = addr_lo[0];
            F3_LW:         mis = (addr_lo != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Lane select plus sign/zero extension of the selected read word.
    function automatic logic [WB_XLEN-1:0] load_format(input logic [2:0] f3,
                                                       input logic [1:0] addr_lo,
                                                       input logic [WB_XLEN-1:0] word);
        logic [7:0]         byte_v;
        logic [15:0]        half_v;
        logic [WB_XLEN-1:0] res;
        case (addr_lo)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        if (addr_lo[1]) begin
            half_v = word[31:16];
        end else begin
            half_v = word[15:0];
        end
        case (f3)
            F3_LB:   res = {{(WB_XLEN-8){byte_v[7]}}, byte_v};
            F3_LH:   res = {{(WB_XLEN-16){half_v[15]}}, half_v};
            F3_LBU:  res = {{(WB_XLEN-8){1'b0}}, byte_v};
            F3_LHU:  res = {{(WB_XLEN-16){1'b0}}, half_v};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_mdu_fifo.sv
// Small synchronous FIFO of {rd, data} MDU results with per-entry rd match
// for the hazard unit.
module wb_mdu_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = WB_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [4:0]      push_rd_i,
    input  logic [XLEN-1:0] push_data_i,
    input  logic            pop_i,
    output logic [4:0]      head_rd_o,
    output logic [XLEN-1:0] head_data_o,
    output logic            full_o,
    output logic            empty_o,
    input  logic [4:0]      query_rd_i,
    output logic            match_o
);

    localparam int AW = $clog2(DEPTH);

    logic [4:0]       rd_mem_r   [DEPTH];
    logic [XLEN-1:0]  data_mem_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             match_s;

    assign full_s    = (count_r == (AW+1)'(DEPTH));
    assign empty_s   = (count_r == '0);
    assign push_ok_s = push_i & ~full_s;
    assign pop_ok_s  = pop_i & ~empty_s;

    // Storage, pointers, occupancy and per-slot valid flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_r[i]   <= '0;
                data_mem_r[i] <= '0;
            end
            valid_r  <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                rd_mem_r[wr_ptr_r]   <= push_rd_i;
                data_mem_r[wr_ptr_r] <= push_data_i;
                valid_r[wr_ptr_r]    <= 1'b1;
                wr_ptr_r             <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Any live entry targeting the queried register
    always_comb begin
        match_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_r[i] && (rd_mem_r[i] == query_rd_i)) begin
                match_s = 1'b1;
            end else begin
                match_s = match_s;
            end
        end
    end

    assign head_rd_o   = rd_mem_r[rd_ptr_r];
    assign head_data_o = data_mem_r[rd_ptr_r];
    assign full_o      = full_s;
    assign empty_o     = empty_s;
    assign match_o     = match_s;

endmodule

// File: rtl/pipeline_wb_arb.sv
// Registered write-back stage: formats loads, arbitrates between in-order
// pipeline results and buffered MDU results, and drives the register-file
// write port. A starvation counter requests a pipeline hold so queued MDU
// results always drain.
module pipeline_wb_arb
    import wb_pkg::*;
#(
    parameter int              XLEN         = WB_XLEN,
    parameter int              MDU_DEPTH    = 4,
    parameter int              STARVE_LIMIT = 8,
    parameter logic [XLEN-1:0] PERIPH_BASE  = 32'h0000_0200
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic            stall_i,
    input  logic [5:0]      opcode_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] alu_out_i,
    input  logic [XLEN-1:0] dmem_read_i,
    input  logic [XLEN-1:0] peripheral_read_i,
    input  logic            mdu_valid_i,
    input  logic [4:0]      mdu_rd_i,
    input  logic [XLEN-1:0] mdu_data_i,
    output logic            mdu_ready_o,
    input  logic [4:0]      rd_query_i,
    output logic            rd_pending_o,
    output logic            stall_req_o,
    output logic            rf_we_o,
    output logic [4:0]      rf_rd_o,
    output logic [XLEN-1:0] rf_data_o,
    output logic            misalign_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    opc_class_e      cls_s;
    logic [2:0]      f3_s;
    logic            fire_s;
    logic            f3_ok_s;
    logic            mis_s;
    logic [XLEN-1:0] load_src_s;
    logic [XLEN-1:0] pipe_data_s;
    logic            pipe_wr_s;
    logic            misalign_s;

    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            fifo_match_s;
    logic [4:0]      head_rd_s;
    logic [XLEN-1:0] head_data_s;
    logic            mdu_acc_s;
    logic            bypass_s;
    logic            push_s;
    logic            pop_s;

    logic            wr_en_s;
    logic [4:0]      wr_rd_s;
    logic [XLEN-1:0] wr_data_s;

    logic [SW-1:0]   starve_cnt_r;
    logic [SW-1:0]   starve_nxt_s;
    logic            stall_nxt_s;
    logic            stall_req_r;
    logic            rf_we_r;
    logic [4:0]      rf_rd_r;
    logic [XLEN-1:0] rf_data_r;
    logic            misalign_r;

    // Decode the pipeline instruction into a write candidate or a misalign drop
    always_comb begin
        cls_s       = opc_class(opcode_i);
        f3_s        = opcode_i[2:0];
        fire_s      = valid_i & ~stall_i;
        f3_ok_s     = load_f3_known(f3_s);
        mis_s       = load_misaligned(f3_s, alu_out_i[1:0]);
        load_src_s  = (alu_out_i >= PERIPH_BASE) ? peripheral_read_i : dmem_read_i;
        pipe_data_s = alu_out_i;
        pipe_wr_s   = 1'b0;
        misalign_s  = 1'b0;
        case (cls_s)
            OPC_ALU, OPC_JMP: begin
                pipe_wr_s = fire_s & (rd_i != 5'd0);
            end
            OPC_LOAD: begin
                pipe_wr_s   = fire_s & (rd_i != 5'd0) & f3_ok_s & ~mis_s;
                misalign_s  = fire_s & f3_ok_s & mis_s;
                pipe_data_s = load_format(f3_s, alu_out_i[1:0], load_src_s);
            end
            default: begin
                pipe_wr_s  = 1'b0;
                misalign_s = 1'b0;
            end
        endcase
    end

    // Readiness depends only on occupancy so the MDU handshake has no loop
    // through the pop decision.
    assign mdu_ready_o = ~fifo_full_s;
    assign mdu_acc_s   = mdu_valid_i & ~fifo_full_s;
    assign pop_s       = ~fifo_empty_s & ~pipe_wr_s;
    assign bypass_s    = fifo_empty_s & ~pipe_wr_s & mdu_acc_s & (mdu_rd_i != 5'd0);
    // rd=0 results are accepted but never stored
    assign push_s      = mdu_acc_s & (mdu_rd_i != 5'd0) & ~bypass_s;

    wb_mdu_fifo #(
        .DEPTH (MDU_DEPTH),
        .XLEN  (XLEN)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_s),
        .push_rd_i   (mdu_rd_i),
        .push_data_i (mdu_data_i),
        .pop_i       (pop_s),
        .head_rd_o   (head_rd_s),
        .head_data_o (head_data_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .query_rd_i  (rd_query_i),
        .match_o     (fifo_match_s)
    );

    assign rd_pending_o = (rd_query_i != 5'd0) & fifo_match_s;

    // Write-port arbitration: pipeline first, then FIFO head, then bypass
    always_comb begin
        wr_en_s   = 1'b0;
        wr_rd_s   = rf_rd_r;
        wr_data_s = rf_data_r;
        if (pipe_wr_s) begin
            wr_en_s   = 1'b1;
            wr_rd_s   = rd_i;
            wr_data_s = pipe_data_s;
        end else if (pop_s) begin
            wr_en_s   = 1'b1;
            wr_rd_s   = head_rd_s;
            wr_data_s = head_data_s;
        end else if (bypass_s) begin
            wr_en_s   = 1'b1;
            wr_rd_s   = mdu_rd_i;
            wr_data_s = mdu_data_i;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Count consecutive waiting cycles of a non-empty FIFO, saturating
    always_comb begin
        starve_nxt_s = starve_cnt_r;
        if (fifo_empty_s || pop_s) begin
            starve_nxt_s = '0;
        end else if (starve_cnt_r < SW'(STARVE_LIMIT)) begin
            starve_nxt_s = starve_cnt_r + SW'(1);
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
        stall_nxt_s = (starve_nxt_s >= SW'(STARVE_LIMIT));
    end

    // Starvation counter and registered hold request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt_r <= '0;
            stall_req_r  <= 1'b0;
        end else begin
            starve_cnt_r <= starve_nxt_s;
            stall_req_r  <= stall_nxt_s;
        end
    end

    // Register-file write port and misalign pulse register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rf_we_r    <= 1'b0;
            rf_rd_r    <= '0;
            rf_data_r  <= '0;
            misalign_r <= 1'b0;
        end else begin
            rf_we_r    <= wr_en_s;
            rf_rd_r    <= wr_rd_s;
            rf_data_r  <= wr_data_s;
            misalign_r <= misalign_s;
        end
    end

    assign stall_req_o = stall_req_r;
    assign rf_we_o     = rf_we_r;
    assign rf_rd_o     = rf_rd_r;
    assign rf_data_o   = rf_data_r;
    assign misalign_o  = misalign_r;

endmodule

// File: tb/tb_pipeline_wb_arb.sv
// Scoreboard bench for pipeline_wb_arb: stimulus pushes expected writes and
// flags into queues, a negedge monitor pops and compares them.
module tb_pipeline_wb_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, stall_i, mdu_valid_i;
    logic [5:0]  opcode_i;
    logic [4:0]  rd_i, mdu_rd_i, rd_query_i;
    logic [31:0] alu_out_i, dmem_read_i, peripheral_read_i, mdu_data_i;
    logic        mdu_ready_o, rd_pending_o, stall_req_o, rf_we_o, misalign_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_data_o;

    pipeline_wb_arb dut (
        .clk_i (clk), .rst_i (rst),
        .valid_i (valid_i), .stall_i (stall_i), .opcode_i (opcode_i), .rd_i (rd_i),
        .alu_out_i (alu_out_i), .dmem_read_i (dmem_read_i),
        .peripheral_read_i (peripheral_read_i),
        .mdu_valid_i (mdu_valid_i), .mdu_rd_i (mdu_rd_i), .mdu_data_i (mdu_data_i),
        .mdu_ready_o (mdu_ready_o), .rd_query_i (rd_query_i), .rd_pending_o (rd_pending_o),
        .stall_req_o (stall_req_o), .rf_we_o (rf_we_o), .rf_rd_o (rf_rd_o),
        .rf_data_o (rf_data_o), .misalign_o (misalign_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [4:0] rd; logic [31:0] data; } wr_t;
    typedef struct { int cyc; logic mis; logic stl; } fl_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;

    wr_t  wr_q[$];
    fl_t  fl_q[$];
    ent_t mq[$];         // MDU results waiting for the write port, oldest first
    int   streak = 0;    // consecutive cycles the queue waited without draining
    logic m_stall = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    wr_t  mw;
    fl_t  mf;

    localparam logic [5:0] OP_ALU  = 6'b000000;
    localparam logic [5:0] OP_JMP  = 6'b111000;
    localparam logic [5:0] OP_STBR = 6'b101000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] dm, input logic [31:0] per);
        logic [31:0] src, b, h;
        src = (a >= 32'h200) ? per : dm;
        b = (src >> (8 * a[1:0])) & 32'hFF;
        h = (src >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
            3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            3'd2:    return src;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    // Monitor: compare registered outputs against queued expectations
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
                mw = wr_q.pop_front();
                chk("rf_we", 32'(rf_we_o), 32'd1);
                if (rf_we_o) begin
                    chk("rf_rd", 32'(rf_rd_o), 32'(mw.rd));
                    chk("rf_data", rf_data_o, mw.data);
                end
            end else begin
                chk("rf_we_idle", 32'(rf_we_o), 32'd0);
            end
            if (fl_q.size() > 0 && fl_q[0].cyc == cyc) begin
                mf = fl_q.pop_front();
                chk("misalign", 32'(misalign_o), 32'(mf.mis));
                chk("stall_req", 32'(stall_req_o), 32'(mf.stl));
            end
        end
    end

    // One clock of stimulus plus the reference model's view of that cycle
    task automatic step(input logic v, input logic st, input logic [5:0] op, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] dm, input logic [31:0] per,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic [4:0] q);
        logic fire, is_ld, known, mis, pw, acc, had, popped, bypassed, exp_ready, exp_pend;
        logic [31:0] pdata;
        ent_t e;
        @(negedge clk);
        #1;
        valid_i = v; stall_i = st; opcode_i = op; rd_i = rd; alu_out_i = alu;
        dmem_read_i = dm; peripheral_read_i = per; mdu_valid_i = mv; mdu_rd_i = mrd;
        mdu_data_i = md; rd_query_i = q;

        fire  = v && !st;
        is_ld = (op[5:3] == 3'b100);
        known = (op[2:0] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = ((op[2:0] == 3'd1 || op[2:0] == 3'd5) && alu[0]) ||
                (op[2:0] == 3'd2 && alu[1:0] != 2'b00);
        pw    = fire && rd != 5'd0 &&
                (!op[5] || op[5:3] == 3'b111 || (is_ld && known && !mis));
        pdata = is_ld ? fmt(op[2:0], alu, dm, per) : alu;

        exp_ready = (mq.size() < 4);
        exp_pend  = 1'b0;
        foreach (mq[i]) if (q != 5'd0 && mq[i].rd == q) exp_pend = 1'b1;
        acc      = mv && exp_ready;
        had      = (mq.size() > 0);
        popped   = 1'b0;
        bypassed = 1'b0;
        if (pw) begin
            wr_q.push_back('{cyc + 1, rd, pdata});
        end else if (had) begin
            e = mq.pop_front();
            wr_q.push_back('{cyc + 1, e.rd, e.data});
            popped = 1'b1;
        end else if (acc && mrd != 5'd0) begin
            wr_q.push_back('{cyc + 1, mrd, md});
            bypassed = 1'b1;
        end
        if (acc && mrd != 5'd0 && !bypassed) mq.push_back('{mrd, md});
        if (!had || popped) streak = 0;
        else streak++;
        m_stall = (streak >= 8);
        fl_q.push_back('{cyc + 1, fire && is_ld && known && mis, m_stall});

        #1;
        chk("mdu_ready", 32'(mdu_ready_o), 32'(exp_ready));
        chk("rd_pending", 32'(rd_pending_o), 32'(exp_pend));
    endtask

    task automatic idle(input logic [4:0] q);
        step(1'b0, m_stall, OP_ALU, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, q);
    endtask

    task automatic do_reset(input logic [4:0] q);
        @(negedge clk);
        #1;
        valid_i = 1'b0; mdu_valid_i = 1'b0; stall_i = 1'b0; rd_query_i = q;
        rst = 1'b1;
        #1;
        chk("rst_rf_we", 32'(rf_we_o), 32'd0);
        chk("rst_rf_rd", 32'(rf_rd_o), 32'd0);
        chk("rst_rf_data", rf_data_o, 32'd0);
        chk("rst_misalign", 32'(misalign_o), 32'd0);
        chk("rst_stall_req", 32'(stall_req_o), 32'd0);
        chk("rst_mdu_ready", 32'(mdu_ready_o), 32'd1);
        chk("rst_rd_pending", 32'(rd_pending_o), 32'd0);
        wr_q.delete(); fl_q.delete(); mq.delete();
        streak = 0; m_stall = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    logic [5:0] rop;
    logic [4:0] rrd;

    initial begin
        valid_i = 1'b0; stall_i = 1'b0; opcode_i = 6'd0; rd_i = 5'd0; alu_out_i = 32'd0;
        dmem_read_i = 32'd0; peripheral_read_i = 32'd0; mdu_valid_i = 1'b0;
        mdu_rd_i = 5'd0; mdu_data_i = 32'd0; rd_query_i = 5'd0;
        rst = 1'b1;
        do_reset(5'd0);

        // Load formatting and misalignment
        step(1'b1, 1'b0, 6'b100000, 5'd1, 32'h003, 32'h80123456, 32'h0, 1'b0, 5'd0, 32'd0, 5'd0);
        step(1'b1, 1'b0, 6'b100100, 5'd2, 32'h003, 32'h80123456, 32'h0, 1'b0, 5'd0, 32'd0, 5'd0);
        step(1'b1, 1'b0, 6'b100001, 5'd3, 32'h202, 32'h0, 32'hBEEF0000, 1'b0, 5'd0, 32'd0, 5'd0);
        step(1'b1, 1'b0, 6'b100010, 5'd4, 32'h006, 32'h11223344, 32'h0, 1'b0, 5'd0, 32'd0, 5'd0);
        step(1'b1, 1'b0, 6'b100111, 5'd4, 32'h004, 32'h11223344, 32'h0, 1'b0, 5'd0, 32'd0, 5'd0);
        step(1'b1, 1'b0, OP_STBR, 5'd6, 32'h10, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0, 5'd0);
        idle(5'd0);

        // Pipeline and MDU collide: x5 first, x7 one cycle later
        step(1'b1, 1'b0, OP_ALU, 5'd5, 32'h55, 32'h0, 32'h0, 1'b1, 5'd7, 32'h77, 5'd7);
        idle(5'd7);
        idle(5'd7);

        // Continuous pipeline writes fill the FIFO until starvation forces a hold
        for (int i = 0; i < 24; i++)
            step(1'b1, m_stall, OP_JMP, 5'(i % 30 + 1), 32'(i * 3), 32'h0, 32'h0,
                 (i < 5), 5'(10 + i), 32'hA000 + 32'(i), 5'(10 + (i % 4)));
        repeat (4) idle(5'd12);

        // rd=0 on both sides never writes
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, OP_ALU, 5'd0, 32'h99, 32'h0, 32'h0, 1'b1, 5'd0, 32'h33, 5'd0);
        idle(5'd0);

        // Reset while three entries are queued
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, OP_ALU, 5'd20, 32'h1, 32'h0, 32'h0, 1'b1, 5'(21 + i), 32'hC0 + 32'(i), 5'd21);
        do_reset(5'd21);
        repeat (3) idle(5'd21);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            case ($urandom % 4)
                0:       rop = {1'b0, 5'($urandom)};
                1:       rop = {3'b100, 3'($urandom)};
                2:       rop = {3'b111, 3'($urandom)};
                default: rop = {1'b1, (($urandom % 2 == 0) ? 2'b01 : 2'b10), 3'($urandom)};
            endcase
            rrd = (rop[5:3] == 3'b100) ? 5'($urandom_range(1, 31)) : 5'($urandom);
            step(($urandom % 4) != 0, m_stall || ($urandom % 8 == 0), rop, rrd,
                 32'($urandom_range(0, 1023)), $urandom, $urandom,
                 ($urandom % 2) == 0, 5'($urandom), $urandom, 5'($urandom));
        end

        // Drain
        repeat (12) idle(5'd0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(wr_q.size()), 32'd0);
        chk("model_queue_empty", 32'(mq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
